bin_up_down_checker: RTL and testbench

BIN_UP_DOWN_CHECKER -- requirements
Module: bin_up_down_checker

---
 rtl/bin_up_down_checker.sv | 102 ++++++++++
 tb/tb_bin_up_down_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_up_down_checker.sv
// Lockstep checker for an up/down counter with load: predicts the next count,
// flags mismatches, counts them, and latches a fault after a run of consecutive misses.
module bin_up_down_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] obs,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             mode,
    input  logic             clr,
    output logic [WIDTH-1:0] exp,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             locked,
    output logic             fault
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t     state;
    logic [3:0] consec;
    logic [4:0] consec_inc;

    // Counter's next value from v for the current control inputs; load beats direction.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
        if (sel)
            return in;
        else if (!mode)
            return v + WIDTH'(1);
        else
            return v - WIDTH'(1);
    endfunction

    assign consec_inc = {1'b0, consec} + 5'd1;

    // NOTE: async reset in the sensitivity list, and <= for every state bit so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_UNLOCKED;
            exp     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            consec  <= '0;
            locked  <= 1'b0;
            fault   <= 1'b0;
        end else if (clr) begin
            state   <= ST_UNLOCKED;
            exp     <= step(obs);
            err     <= 1'b0;
            err_cnt <= '0;
            consec  <= '0;
            locked  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    exp    <= step(obs);
                    err    <= 1'b0;
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end
                ST_LOCKED: begin
                    if (obs == exp) begin
                        exp    <= step(exp);
                        consec <= '0;
                        err    <= 1'b0;
                    end else begin
                        // Reseed from the observed value so one glitch costs one error.
                        exp    <= step(obs);
                        err    <= 1'b1;
                        consec <= consec_inc[3:0];
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                        if (consec_inc == 5'(ERR_LIMIT)) begin
                            state  <= ST_FAULT;
                            fault  <= 1'b1;
                            locked <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    exp <= step(obs);
                    err <= 1'b0;
                end
                default: begin
                    state  <= ST_UNLOCKED;
                    locked <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_up_down_checker.sv
// Bench for bin_up_down_checker: a reference counter drives obs, a rule-level model
// predicts every output each cycle, and directed literals pin the key scenarios.
module tb_bin_up_down_checker;

    localparam int WIDTH = 4;
    localparam int LIMIT = 3;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] obs = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic             sel = 1'b0;
    logic             mode = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] exp;
    logic             err;
    logic [7:0]       err_cnt;
    logic             locked;
    logic             fault;

    int n_cmp  = 0;
    int n_fail = 0;
    int ctr    = 0;

    // Model of the checker's observable behaviour.
    bit m_synced = 0;
    bit m_fault  = 0;
    int m_run    = 0;
    int m_cnt    = 0;
    int m_exp    = 0;
    bit m_err    = 0;

    bin_up_down_checker #(.WIDTH(WIDTH), .ERR_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .obs     (obs),
        .in      (load_val),
        .sel     (sel),
        .mode    (mode),
        .clr     (clr),
        .exp     (exp),
        .err     (err),
        .err_cnt (err_cnt),
        .locked  (locked),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int v, input bit s, input int i, input bit m);
        if (s) return i % MOD;
        return m ? (v + MOD - 1) % MOD : (v + 1) % MOD;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_synced = 0; m_fault = 0; m_run = 0; m_cnt = 0; m_exp = 0; m_err = 0;
        end else if (clr) begin
            m_synced = 0; m_fault = 0; m_run = 0; m_cnt = 0; m_err = 0;
            m_exp = nxt(int'(obs), sel, int'(load_val), mode);
        end else if (m_fault || !m_synced) begin
            m_synced = 1;
            m_err = 0;
            m_exp = nxt(int'(obs), sel, int'(load_val), mode);
        end else if (int'(obs) == m_exp) begin
            m_err = 0;
            m_run = 0;
            m_exp = nxt(m_exp, sel, int'(load_val), mode);
        end else begin
            m_err = 1;
            m_run = m_run + 1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_exp = nxt(int'(obs), sel, int'(load_val), mode);
            if (m_run == LIMIT) m_fault = 1;
        end
    end

    always @(negedge clk) begin
        check("exp",     int'(exp),     m_exp);
        check("err",     int'(err),     int'(m_err));
        check("err_cnt", int'(err_cnt), m_cnt);
        check("locked",  int'(locked),  int'(m_synced && !m_fault));
        check("fault",   int'(fault),   int'(m_fault));
    end

    // One clock of stimulus; ovr forces the observed counter to ov before the edge.
    task automatic cyc(input bit s, input int i, input bit m, input bit c,
                       input bit ovr, input int ov);
        @(negedge clk);
        if (ovr) ctr = ov % MOD;
        obs = WIDTH'(ctr);
        sel = s; load_val = WIDTH'(i); mode = m; clr = c;
        @(posedge clk);
        ctr = nxt(ctr, s, i, m);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exp"},     int'(exp),     0);
        check({tag, "_err"},     int'(err),     0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_locked"},  int'(locked),  0);
        check({tag, "_fault"},   int'(fault),   0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_all_zero("rst");
        #1 reset = 1'b1;

        // Load 5, then count up 13 times through the wrap.
        cyc(1, 5, 0, 0, 0, 0);
        check("lock_after_first_edge", int'(locked), 1);
        check("exp_after_load5", int'(exp), 5);
        repeat (13) cyc(0, 0, 0, 0, 0, 0);
        check("up_wrap_exp", int'(exp), 2);
        check("up_wrap_errcnt", int'(err_cnt), 0);

        // Load 2 and count down across zero.
        cyc(1, 2, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 0, 0, 0);
        check("down_wrap_exp", int'(exp), 14);
        check("down_wrap_errcnt", int'(err_cnt), 0);

        // Single glitch: exp=9 but obs=12, then the counter carries on 13,14.
        cyc(1, 8, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("exp_is_9", int'(exp), 9);
        cyc(0, 0, 0, 0, 1, 12);
        check("glitch_err", int'(err), 1);
        check("glitch_errcnt", int'(err_cnt), 1);
        check("glitch_reseed", int'(exp), 13);
        cyc(0, 0, 0, 0, 0, 0);
        check("glitch_err_drop", int'(err), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("glitch_locked", int'(locked), 1);
        check("glitch_errcnt_hold", int'(err_cnt), 1);

        // clr together with a mismatch: clr wins.
        cyc(0, 0, 0, 1, 1, (ctr + 3) % MOD);
        check("clr_mismatch_err", int'(err), 0);
        check("clr_mismatch_cnt", int'(err_cnt), 0);
        check("clr_unlocked", int'(locked), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("clr_relock", int'(locked), 1);

        // obs stuck at 7 while counting up.
        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 7);
        check("stuck_err1", int'(err), 1);
        cyc(0, 0, 0, 0, 1, 7);
        check("stuck_err2", int'(err), 1);
        cyc(0, 0, 0, 0, 1, 7);
        check("stuck_err3", int'(err), 1);
        check("stuck_fault", int'(fault), 1);
        check("stuck_unlocked", int'(locked), 0);
        check("stuck_cnt3", int'(err_cnt), 3);
        repeat (2) cyc(0, 0, 0, 0, 1, 7);
        check("fault_no_err", int'(err), 0);
        check("fault_cnt_frozen", int'(err_cnt), 3);
        check("fault_sticky", int'(fault), 1);

        // Clear the fault.
        cyc(0, 0, 0, 1, 0, 0);
        check("clr_fault", int'(fault), 0);
        check("clr_cnt", int'(err_cnt), 0);
        check("clr_locked0", int'(locked), 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("clr_locked1", int'(locked), 1);

        // Alternate mismatch/match long enough to saturate err_cnt without faulting.
        repeat (260) begin
            cyc(0, 0, 0, 0, 1, (ctr + 8) % MOD);
            cyc(0, 0, 0, 0, 0, 0);
        end
        check("sat_cnt", int'(err_cnt), 255);
        check("sat_no_fault", int'(fault), 0);

        // Two mismatches, then asynchronous reset between edges.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, (ctr + 5) % MOD);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, (ctr + 5) % MOD);
        check("pre_reset_cnt", int'(err_cnt), 2);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #2 reset = 1'b1;
        ctr = 0;
        cyc(0, 0, 0, 0, 0, 0);
        check("post_rst_locked", int'(locked), 1);
        check("post_rst_err", int'(err), 0);
        check("post_rst_exp", int'(exp), 1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
